// File: rtl/siren_pkg.sv
// Shared types for the siren pattern generator: FSM state encoding, pattern
// mode constants and the decoder that folds the raw mode input onto a mode.
package siren_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_ON  = 2'd1,
    RUN_OFF = 2'd2,
    GAP     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_ALT    = 2'd0,
    MODE_STROBE = 2'd1,
    MODE_STEADY = 2'd2
  } mode_t;

  // The unused encoding 3 behaves exactly like the alternating pattern.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_STROBE;
      2'd2:    return MODE_STEADY;
      default: return MODE_ALT;
    endcase
  endfunction

endpackage

// File: rtl/siren_mod_counter.sv
// Modulo-MODULUS counter with synchronous clear, increment enable and a flag
// that is high while the count sits at its terminal value MODULUS-1.
module siren_mod_counter #(
  parameter int MODULUS = 2,
  parameter int W       = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  assign wrap = (count == LAST);

  // count_next is exported so the parent can register outputs that depend on
  // the value the counter is about to take.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (inc) begin
      count_next = wrap ? '0 : count + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/siren_pattern_gen.sv
// Multi-light siren pattern generator: alternating, strobe-burst and steady
// patterns stepped by an external slow tick, with fully registered outputs.
module siren_pattern_gen
  import siren_pkg::*;
#(
  parameter int N_LIGHTS  = 2,
  parameter int BURST_LEN = 3,
  parameter int GAP_TICKS = 2,
  parameter int CW        = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable_siren,
  input  logic                tick,
  input  logic [1:0]          mode,
  output logic                siren,
  output logic                tone,
  output logic [N_LIGHTS-1:0] lights,
  output logic [CW-1:0]       color
);

  localparam int FW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GAP_MOD = (GAP_TICKS > 0) ? GAP_TICKS : 1;
  localparam int GW      = (GAP_MOD > 1) ? $clog2(GAP_MOD) : 1;
  localparam logic [N_LIGHTS-1:0] ONE_LIGHT = N_LIGHTS'(1);

  state_t state, state_n;
  mode_t  mode_q, mode_n;
  logic   tone_n;
  logic   clr_all, idx_inc, flash_inc, flash_clr, gap_inc, gap_clr;

  logic [CW-1:0] idx, idx_next;
  logic [FW-1:0] flash_cnt, flash_next;
  logic [GW-1:0] gap_cnt, gap_next;
  logic          idx_wrap, flash_wrap, gap_wrap;

  logic [N_LIGHTS-1:0] lights_n;
  logic [CW-1:0]       color_n;
  logic                siren_n;

  siren_mod_counter #(.MODULUS(N_LIGHTS), .W(CW)) u_idx (
    .clock      (clock),
    .reset      (reset),
    .clear      (clr_all),
    .inc        (idx_inc),
    .count      (idx),
    .count_next (idx_next),
    .wrap       (idx_wrap)
  );

  siren_mod_counter #(.MODULUS(BURST_LEN), .W(FW)) u_flash (
    .clock      (clock),
    .reset      (reset),
    .clear      (clr_all | flash_clr),
    .inc        (flash_inc),
    .count      (flash_cnt),
    .count_next (flash_next),
    .wrap       (flash_wrap)
  );

  siren_mod_counter #(.MODULUS(GAP_MOD), .W(GW)) u_gap (
    .clock      (clock),
    .reset      (reset),
    .clear      (clr_all | gap_clr),
    .inc        (gap_inc),
    .count      (gap_cnt),
    .count_next (gap_next),
    .wrap       (gap_wrap)
  );

  // Dropping enable beats any tick on the same edge; mode is only sampled
  // on the IDLE -> RUN_ON edge so mid-run changes have no effect.
  always_comb begin
    state_n   = state;
    mode_n    = mode_q;
    tone_n    = tone;
    clr_all   = 1'b0;
    idx_inc   = 1'b0;
    flash_inc = 1'b0;
    flash_clr = 1'b0;
    gap_inc   = 1'b0;
    gap_clr   = 1'b0;
    if (!enable_siren) begin
      state_n = IDLE;
      clr_all = 1'b1;
      tone_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = RUN_ON;
          mode_n  = decode_mode(mode);
          clr_all = 1'b1;
          tone_n  = 1'b0;
        end
        RUN_ON: begin
          if (tick) begin
            case (mode_q)
              MODE_STROBE: state_n = RUN_OFF;
              MODE_STEADY: state_n = RUN_ON;
              default: begin
                idx_inc = 1'b1;
                tone_n  = ~tone;
              end
            endcase
          end
        end
        RUN_OFF: begin
          if (tick) begin
            if (!flash_wrap) begin
              flash_inc = 1'b1;
              state_n   = RUN_ON;
            end else begin
              flash_clr = 1'b1;
              if (GAP_TICKS == 0) begin
                state_n = RUN_ON;
                idx_inc = 1'b1;
                tone_n  = ~tone;
              end else begin
                state_n = GAP;
              end
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (!gap_wrap) begin
              gap_inc = 1'b1;
            end else begin
              gap_clr = 1'b1;
              state_n = RUN_ON;
              idx_inc = 1'b1;
              tone_n  = ~tone;
            end
          end
        end
        default: begin
          state_n = IDLE;
          clr_all = 1'b1;
          tone_n  = 1'b0;
        end
      endcase
    end
  end

  // Outputs are decoded from the upcoming state so the registered copies
  // line up with the edge at which the state changes.
  always_comb begin
    lights_n = '0;
    color_n  = '0;
    siren_n  = (state_n != IDLE);
    if (state_n != IDLE) begin
      color_n = idx_next;
    end
    if (state_n == RUN_ON) begin
      lights_n = (mode_n == MODE_STEADY) ? '1 : (ONE_LIGHT << idx_next);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      mode_q <= MODE_ALT;
      tone   <= 1'b0;
      siren  <= 1'b0;
      lights <= '0;
      color  <= '0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      tone   <= tone_n;
      siren  <= siren_n;
      lights <= lights_n;
      color  <= color_n;
    end
  end

endmodule

// File: tb/tb_siren_pattern_gen.sv
// Self-checking bench: two generator instances (3-light with strobe gap, and
// 2-light with single flash and no gap) driven from a vector table.
module tb_siren_pattern_gen;

  typedef struct {
    bit         sel;
    logic       rst;
    logic       en;
    logic       tk;
    logic [1:0] md;
    logic [2:0] lt;
    logic [1:0] cl;
    logic       tn;
    logic       sr;
    string      nm;
  } vec_t;

  typedef struct {
    bit         sel;
    logic [2:0] lt;
    logic [1:0] cl;
    logic       tn;
    logic       sr;
    string      nm;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en_a = 1'b0, tick_a = 1'b0;
  logic [1:0] mode_a = 2'd0;
  logic       en_b = 1'b0, tick_b = 1'b0;
  logic [1:0] mode_b = 2'd0;

  logic       siren_a, tone_a;
  logic [2:0] lights_a;
  logic [1:0] color_a;
  logic       siren_b, tone_b;
  logic [1:0] lights_b;
  logic [0:0] color_b;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clock = ~clock;

  siren_pattern_gen #(.N_LIGHTS(3), .BURST_LEN(2), .GAP_TICKS(2)) dut_a (
    .clock        (clock),
    .reset        (reset),
    .enable_siren (en_a),
    .tick         (tick_a),
    .mode         (mode_a),
    .siren        (siren_a),
    .tone         (tone_a),
    .lights       (lights_a),
    .color        (color_a)
  );

  siren_pattern_gen #(.N_LIGHTS(2), .BURST_LEN(1), .GAP_TICKS(0)) dut_b (
    .clock        (clock),
    .reset        (reset),
    .enable_siren (en_b),
    .tick         (tick_b),
    .mode         (mode_b),
    .siren        (siren_b),
    .tone         (tone_b),
    .lights       (lights_b),
    .color        (color_b)
  );

  function automatic vec_t mk(bit sel, logic rst, logic en, logic tk, logic [1:0] md,
                              logic [2:0] lt, logic [1:0] cl, logic tn, logic sr, string nm);
    vec_t v;
    v.sel = sel; v.rst = rst; v.en = en; v.tk = tk; v.md = md;
    v.lt = lt; v.cl = cl; v.tn = tn; v.sr = sr; v.nm = nm;
    return v;
  endfunction

  task automatic check_output();
    exp_t       e;
    logic [6:0] act, want;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: got no expected entry, want one");
      return;
    end
    e = sb.pop_front();
    if (e.sel) act = {1'b0, lights_b, 1'b0, color_b, tone_b, siren_b};
    else       act = {lights_a, color_a, tone_a, siren_a};
    want = {e.lt, e.cl, e.tn, e.sr};
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got lights=%b color=%0d tone=%b siren=%b, want lights=%b color=%0d tone=%b siren=%b",
               e.nm, act[6:4], act[3:2], act[1], act[0], want[6:4], want[3:2], want[1], want[0]);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    @(negedge clock);
    reset = v.rst;
    if (v.sel) begin
      en_b = v.en; tick_b = v.tk; mode_b = v.md;
    end else begin
      en_a = v.en; tick_a = v.tk; mode_a = v.md;
    end
    e.sel = v.sel; e.lt = v.lt; e.cl = v.cl; e.tn = v.tn; e.sr = v.sr; e.nm = v.nm;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_output();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // reset held low with enable and tick active
    tbl.push_back(mk(0, 0, 1, 1, 2'd0, 3'b000, 2'd0, 0, 0, "rst_tick"));
    tbl.push_back(mk(0, 0, 1, 0, 2'd0, 3'b000, 2'd0, 0, 0, "rst_hold"));
    tbl.push_back(mk(0, 0, 1, 1, 2'd1, 3'b000, 2'd0, 0, 0, "rst_tick2"));
    // strobe burst of two flashes followed by a two-tick gap
    tbl.push_back(mk(0, 1, 1, 0, 2'd1, 3'b001, 2'd0, 0, 1, "stb_start"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 3'b000, 2'd0, 0, 1, "stb_t1"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 3'b001, 2'd0, 0, 1, "stb_t2"));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 3'b001, 2'd0, 0, 1, "stb_notick"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd0, 3'b000, 2'd0, 0, 1, "stb_t3"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 3'b000, 2'd0, 0, 1, "stb_t4"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 3'b000, 2'd0, 0, 1, "stb_t5"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 3'b010, 2'd1, 1, 1, "stb_t6"));
    tbl.push_back(mk(0, 1, 0, 0, 2'd1, 3'b000, 2'd0, 0, 0, "stb_off"));
    // steady ignores ticks and a mid-run mode change
    tbl.push_back(mk(0, 1, 1, 0, 2'd2, 3'b111, 2'd0, 0, 1, "std_start"));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 1, 1, 2'd0, 3'b111, 2'd0, 0, 1, "std_tick"));
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 3'b000, 2'd0, 0, 0, "std_off"));
    // alternate through the wrap, then disable on a tick edge
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 3'b001, 2'd0, 0, 1, "alt_start"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd0, 3'b010, 2'd1, 1, 1, "alt_t1"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd0, 3'b100, 2'd2, 0, 1, "alt_t2"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd0, 3'b001, 2'd0, 1, 1, "alt_wrap"));
    tbl.push_back(mk(0, 1, 0, 1, 2'd0, 3'b000, 2'd0, 0, 0, "alt_off_tick"));
    // mode 3 behaves as alternate
    tbl.push_back(mk(0, 1, 1, 0, 2'd3, 3'b001, 2'd0, 0, 1, "m3_start"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd3, 3'b010, 2'd1, 1, 1, "m3_t1"));
    tbl.push_back(mk(0, 1, 0, 0, 2'd3, 3'b000, 2'd0, 0, 0, "m3_off"));
    // re-enable restarts at idx 0
    tbl.push_back(mk(0, 1, 1, 0, 2'd1, 3'b001, 2'd0, 0, 1, "gap_start"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 3'b000, 2'd0, 0, 1, "gap_t1"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 3'b001, 2'd0, 0, 1, "gap_t2"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 3'b000, 2'd0, 0, 1, "gap_t3"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 3'b000, 2'd0, 0, 1, "gap_t4"));
    // reset pulse while in GAP, then restart in the newly latched mode
    tbl.push_back(mk(0, 0, 1, 0, 2'd0, 3'b000, 2'd0, 0, 0, "gap_reset"));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 3'b001, 2'd0, 0, 1, "post_rst"));
    tbl.push_back(mk(0, 1, 1, 1, 2'd0, 3'b010, 2'd1, 1, 1, "post_rst_t1"));

    foreach (tbl[i]) apply_stimulus(tbl[i]);

    // two-light instance: alternate, then single-flash strobe with no gap
    apply_stimulus(mk(1, 1, 1, 0, 2'd0, 3'b001, 2'd0, 0, 1, "b_alt_start"));
    apply_stimulus(mk(1, 1, 1, 1, 2'd0, 3'b010, 2'd1, 1, 1, "b_alt_t1"));
    apply_stimulus(mk(1, 1, 1, 1, 2'd0, 3'b001, 2'd0, 0, 1, "b_alt_t2"));
    apply_stimulus(mk(1, 1, 0, 0, 2'd0, 3'b000, 2'd0, 0, 0, "b_off"));
    apply_stimulus(mk(1, 1, 1, 0, 2'd1, 3'b001, 2'd0, 0, 1, "b_stb_start"));
    apply_stimulus(mk(1, 1, 1, 1, 2'd1, 3'b000, 2'd0, 0, 1, "b_stb_t1"));
    apply_stimulus(mk(1, 1, 1, 1, 2'd1, 3'b010, 2'd1, 1, 1, "b_stb_nogap"));
    apply_stimulus(mk(1, 1, 1, 1, 2'd1, 3'b000, 2'd1, 1, 1, "b_stb_t3"));
    apply_stimulus(mk(1, 1, 1, 1, 2'd1, 3'b001, 2'd0, 0, 1, "b_stb_wrap"));

    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_left: got %0d entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/siren_pattern_gen.md
Name: siren_pattern_gen

Overview:
Parametrised successor to the two-colour siren generator: drives N_LIGHTS light outputs plus a siren/tone pair from an external slow tick, the 2 Hz enable pulse. Three selectable patterns: alternating, strobe bursts with gap, and steady. Sits between the tick prescaler and the light/buzzer drivers. All outputs are registered.

Parameters:
N_LIGHTS, 2, number of light channels; must be >= 2.
BURST_LEN, 3, on/off flashes per light in STROBE mode; must be >= 1.
GAP_TICKS, 2, all-dark ticks between strobe bursts; 0 means no gap.
CW, $clog2(N_LIGHTS) (min 1), width of the color index output.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
enable_siren  input  1  level; high runs the pattern, low forces idle.
tick  input  1  one-cycle pulse, the 2 Hz enable; advances the pattern.
mode  input  2  0 ALTERNATE, 1 STROBE, 2 STEADY, 3 treated as ALTERNATE.
siren  output  1  buzzer on; high whenever not idle.
tone  output  1  high/low tone select; toggles on each light-index advance.
lights  output  N_LIGHTS  light drive, one-hot or all-ones or zero.
color  output  CW  index of the current light.

Behaviour:
- Reset (reset==0 at an edge): state IDLE; siren=0, tone=0, lights=0, color=0; all counters 0. Reset overrides all other inputs.
- States: IDLE, RUN_ON, RUN_OFF, GAP. Internal counters: idx (0..N_LIGHTS-1), flash_cnt (0..BURST_LEN-1), gap_cnt (0..GAP_TICKS-1).
- IDLE -> RUN_ON at the first edge with enable_siren=1. mode is latched at this edge. mode changes during a run are ignored until the block returns to IDLE. Outputs take effect from that edge: siren=1, idx=0, tone=0.
- In any non-IDLE state, enable_siren=0 at an edge -> IDLE with all outputs 0 and counters cleared. This takes priority over a simultaneous tick.
- Ticks are acted on only at edges where tick=1; with no tick, state and outputs hold.
- ALTERNATE: RUN_ON only. Each tick: idx = (idx==N_LIGHTS-1) ? 0 : idx+1, and tone toggles. lights = one-hot(idx).
- STROBE:
  - RUN_ON: lights = one-hot(idx). On tick -> RUN_OFF.
  - RUN_OFF: lights = 0. On tick, if flash_cnt < BURST_LEN-1: flash_cnt++ and -> RUN_ON with the same idx.
  - RUN_OFF, last flash: flash_cnt=0, then -> GAP, or, if GAP_TICKS==0, -> RUN_ON with idx advanced and tone toggled.
  - GAP: lights = 0. On tick, if gap_cnt < GAP_TICKS-1: gap_cnt++. Otherwise gap_cnt=0 and -> RUN_ON with idx advanced (wrapping) and tone toggled.
- STEADY: RUN_ON only. lights = all ones, tone = 0, ticks ignored. color holds 0.
- color = idx in every non-IDLE state, including RUN_OFF and GAP.
- siren = 1 in every non-IDLE state.
- Re-enable after disable always restarts at idx 0, flash_cnt 0, and the newly latched mode.

Decomposition:
- Shared package/header siren_pkg: state encodings (IDLE, RUN_ON, RUN_OFF, GAP) and mode constants (MODE_ALT=0, MODE_STROBE=1, MODE_STEADY=2).
- One sub-module, siren_mod_counter: a parametrised modulo-N counter with clear, inc-enable and a wrap flag. It is instantiated three times, for idx, flash_cnt and gap_cnt.

Test Plan:
1. Hold reset=0 for 2 cycles with enable_siren=1 and tick pulsing -> siren=0, tone=0, lights=0, color=0 throughout.
2. N_LIGHTS=2, mode=0, enable_siren=1 -> next edge lights=01, color=0, siren=1, tone=0. Tick -> lights=10, color=1, tone=1. Tick -> lights=01, color=0, tone=0.
3. N_LIGHTS=3, BURST_LEN=2, GAP_TICKS=2, mode=1 -> start lights=001. After ticks 1..6, lights = 000, 001, 000, 000, 000, 010. At tick 6, color=1 and tone=1.
4. N_LIGHTS=3, mode=2 -> lights=111, tone=0, color=0. Then apply 5 ticks and change mode to 0 mid-run -> outputs unchanged.
5. N_LIGHTS=3, mode=0, advance to color=2 -> tick gives color=0, lights=001. Then deassert enable_siren on the same edge as a tick -> next edge all outputs 0.
6. Strobe run in GAP state, pulse reset=0 for 1 cycle with enable_siren held 1 and mode=0 -> all outputs 0 during reset. The following edge restarts in ALTERNATE with lights=001 and color=0.
